div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 30 +++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Operation codes, FSM state encoding and small decode helpers shared by the
// divider, the ALU and the control unit.
package div_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] SEL_DIV  = 5'b01110;
    localparam logic [4:0] SEL_REM  = 5'b01111;
    localparam logic [4:0] SEL_REMU = 5'b10000;
    localparam logic [4:0] SEL_DIVU = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic sel_legal(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_REM) || (sel == SEL_REMU) || (sel == SEL_DIVU);
    endfunction

    function automatic logic sel_signed(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_REM);
    endfunction

    function automatic logic sel_is_div(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_DIVU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial
// subtract the divisor, restore on borrow and emit one quotient bit.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[DATA_W-1]};
        diff    = shifted - {1'b0, divisor};
        // Borrow out of the top bit means the trial subtract went negative.
        if (diff[DATA_W]) begin
            rem_out = shifted[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b0};
        end else begin
            rem_out = diff[DATA_W-1:0];
            quo_out = {quo_in[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/REM/DIVU/REMU with a busy stall, a one-cycle
// done pulse, divide-by-zero and signed-overflow bypass, and pipeline flush.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        FLUSH,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [4:0]  SELECT,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    div_state_e        state, state_nxt;
    logic [4:0]        sel_q;
    logic [DATA_W-1:0] op1, op2, dvs, rem, quo, result_q;
    logic [DATA_W-1:0] step_rem, step_quo;
    logic              sign1, sign2, run;
    logic [4:0]        cnt;
    logic              accept, div_zero, ovf, bypass, last;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        logic signed [DATA_W-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    function automatic logic [DATA_W-1:0] bypass_result(input logic [4:0] sel, input logic zero,
                                                        input logic [DATA_W-1:0] dividend);
        if (zero)
            return sel_is_div(sel) ? '1 : dividend;
        return sel_is_div(sel) ? 32'h8000_0000 : '0;
    endfunction

    function automatic logic [DATA_W-1:0] fixup(input logic [4:0] sel, input logic s1, input logic s2,
                                                input logic [DATA_W-1:0] q, input logic [DATA_W-1:0] r);
        return sel_is_div(sel) ? neg_if(q, s1 ^ s2) : neg_if(r, s1);
    endfunction

    assign accept   = (state == ST_IDLE) && START && !FLUSH && sel_legal(SELECT);
    assign div_zero = (op2 == '0);
    assign ovf      = sel_signed(sel_q) && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    assign bypass   = div_zero || ovf;
    assign last     = run && (cnt == 5'd31);

    div_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CALC;
            ST_CALC: begin
                if (FLUSH)
                    state_nxt = ST_IDLE;
                else if ((!run && bypass) || last)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state != ST_IDLE);
        DONE   = (state == ST_DONE);
        RESULT = result_q;
    end

    // First CALC cycle prepares magnitudes or takes the bypass; the next 32 each retire one quotient bit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q    <= '0;
            op1      <= '0;
            op2      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            run      <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            sel_q <= SELECT;
            op1   <= DATA1;
            op2   <= DATA2;
            sign1 <= sel_signed(SELECT) & DATA1[DATA_W-1];
            sign2 <= sel_signed(SELECT) & DATA2[DATA_W-1];
            run   <= 1'b0;
            cnt   <= '0;
        end else if (state == ST_CALC) begin
            if (FLUSH) begin
                run <= 1'b0;
                cnt <= '0;
            end else if (!run) begin
                if (bypass) begin
                    result_q <= bypass_result(sel_q, div_zero, op1);
                end else begin
                    rem <= '0;
                    quo <= neg_if(op1, sign1);
                    dvs <= neg_if(op2, sign2);
                    run <= 1'b1;
                end
            end else begin
                rem <= step_rem;
                quo <= step_quo;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    result_q <= fixup(sel_q, sign1, sign2, step_quo, step_rem);
                    run      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        CLK, RESET_N, START, FLUSH;
    logic [31:0] DATA1, DATA2, RESULT;
    logic [4:0]  SELECT;
    logic        BUSY, DONE;

    int n_checks = 0;
    int n_pass   = 0;

    div_unit dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .FLUSH   (FLUSH),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .SELECT  (SELECT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0)
            return (sel == SEL_DIV || sel == SEL_DIVU) ? 32'hFFFF_FFFF : a;
        case (sel)
            SEL_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : $unsigned(sa / sb);
            SEL_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : $unsigned(sa % sb);
            SEL_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (b == 0)
            return 1;
        if ((sel == SEL_DIV || sel == SEL_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    // Issues one START, waits (bounded) for DONE; lat is the edge count after the START edge.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic tail);
        res = '0;
        lat = -1;
        @(negedge CLK);
        SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = k;
                res = RESULT;
                break;
            end
        end
        @(posedge CLK); #1;
        tail = DONE | BUSY;
    endtask

    initial begin
        logic [31:0] res, prev, a, b;
        logic [4:0]  sel;
        logic        tail;
        int          lat, n_done, done_at;
        logic [4:0]  ops[4];

        ops = '{SEL_DIV, SEL_REM, SEL_DIVU, SEL_REMU};
        vecs[0]  = '{SEL_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
        vecs[1]  = '{SEL_REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         33};
        vecs[2]  = '{SEL_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 33};
        vecs[3]  = '{SEL_REMU, 32'd7,          32'd0,         32'd7,         1};
        vecs[4]  = '{SEL_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[5]  = '{SEL_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[6]  = '{SEL_DIV,  32'd7,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[7]  = '{SEL_REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33};
        vecs[8]  = '{SEL_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
        vecs[9]  = '{SEL_DIVU, 32'd123456789,  32'd1000,      32'd123456,    33};
        vecs[10] = '{SEL_REMU, 32'd123456789,  32'd1000,      32'd789,       33};

        RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0;
        DATA1 = '0; DATA2 = '0; SELECT = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Illegal operation code must not start anything.
        @(negedge CLK);
        START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd9; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        check("illegal_sel_busy", {31'd0, BUSY}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat, tail);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_single_pulse", i), {31'd0, tail}, 32'd0);
        end

        // Overflow bypass: BUSY for two cycles, DONE in the second.
        @(negedge CLK);
        SELECT = SEL_DIV; DATA1 = 32'h8000_0000; DATA2 = 32'hFFFF_FFFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("ovf_c1_busy_done", {30'd0, BUSY, DONE}, 32'd2);
        @(posedge CLK); #1;
        check("ovf_c2_busy_done", {30'd0, BUSY, DONE}, 32'd3);
        check("ovf_result", RESULT, 32'h8000_0000);
        @(posedge CLK); #1;
        check("ovf_c3_busy_done", {30'd0, BUSY, DONE}, 32'd0);

        // START pulses during CALC with new operands are ignored.
        @(negedge CLK);
        SELECT = SEL_DIV; DATA1 = 32'd100; DATA2 = 32'hFFFF_FFF9; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        n_done = 0; done_at = -1; res = '0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge CLK);
            if (i == 5 || i == 17 || i == 30) begin
                START = 1'b1; SELECT = SEL_DIVU; DATA1 = $urandom; DATA2 = $urandom | 32'd1;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            if (DONE) begin
                n_done++;
                done_at = i;
                res = RESULT;
            end
        end
        START = 1'b0;
        check("busy_start_done_count", 32'(n_done), 32'd1);
        check("busy_start_latency", 32'(done_at), 32'd33);
        check("busy_start_result", res, 32'hFFFF_FFF2);

        // FLUSH at CALC cycle 10, then a normal operation two cycles later.
        prev = RESULT;
        @(negedge CLK);
        SELECT = SEL_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        check("flush_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        check("flush_result_held", RESULT, prev);
        @(negedge CLK);
        FLUSH = 1'b0;
        @(posedge CLK);
        run_op(SEL_DIVU, 32'd1000, 32'd3, res, lat, tail);
        check("post_flush_result", res, 32'd333);
        check("post_flush_latency", 32'(lat), 32'd33);

        // Reset at CALC cycle 20 clears outputs immediately and kills the operation.
        @(negedge CLK);
        SELECT = SEL_DIVU; DATA1 = 32'd5000; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (19) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("async_reset_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        check("async_reset_result", RESULT, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (DONE) n_done++;
        end
        check("post_reset_no_done", 32'(n_done), 32'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            sel = ops[$urandom_range(0, 3)];
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            run_op(sel, a, b, res, lat, tail);
            check($sformatf("rand%0d_result sel=%b a=%h b=%h", i, sel, a, b), res, model_result(sel, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_latency(sel, a, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
